// File: rtl/bus_pkg.sv
// Shared constants for the bus arbiter: arbitration modes and counter width.
package bus_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/bus_rr_pick.sv
// Rotating-base priority encoder: finds the first set request bit searching
// upward from base and wrapping from N-1 to 0. Purely combinational.
module bus_rr_pick #(
  parameter int N  = 24,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          found,
  output logic [IW-1:0] idx
);

  // One extra bit so base + offset never overflows before the wrap correction.
  localparam int JW = IW + 1;

  logic [JW-1:0] j;

  // Scan N positions starting at base; the first set bit wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, base} + JW'(k);
      if (j >= JW'(N)) j = j - JW'(N);
      if (!found && req[j[IW-1:0]]) begin
        found = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arb_reg.sv
// Registered bus arbiter: selects one of NSRC sources per capture cycle
// (fixed priority or round-robin), registers the winning word with a
// valid/ready hold stage, and flags/counts multi-request conflicts.
module bus_arb_reg
  import bus_pkg::*;
#(
  parameter int        WIDTH = 32,
  parameter int        NSRC  = 24,
  parameter arb_mode_e MODE  = ARB_FIXED,
  parameter int        HOLD  = 0
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NSRC-1:0]          sel,
  input  logic [NSRC*WIDTH-1:0]    data_in,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [$clog2(NSRC)-1:0]  bus_src,
  output logic                     conflict,
  output logic [CNT_W-1:0]         conflict_count
);

  localparam int SW = $clog2(NSRC);
  localparam logic [NSRC-1:0] SEL_ONE = NSRC'(1);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    pick_base;
  logic [SW-1:0]    win_idx;
  logic [SW-1:0]    next_ptr;
  logic             win_found;
  logic [WIDTH-1:0] win_data;
  logic             capture;
  logic             multi;

  // Fixed priority is just the rotating encoder pinned to base 0.
  assign pick_base = (MODE == ARB_RR) ? ptr : '0;

  bus_rr_pick #(.N(NSRC), .IW(SW)) u_pick (
    .req   (sel),
    .base  (pick_base),
    .found (win_found),
    .idx   (win_idx)
  );

  // The output stage accepts a new word when empty or when the consumer takes the current one.
  assign capture  = !bus_valid || out_ready;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi    = (sel & (sel - SEL_ONE)) != '0;
  assign next_ptr = (win_idx == SW'(NSRC - 1)) ? '0 : win_idx + SW'(1);

  // Data mux for the granted source.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (win_idx == SW'(i)) win_data = data_in[i*WIDTH +: WIDTH];
    end
  end

  // Output stage, RR pointer and conflict tracking; nothing but the hold changes outside capture cycles.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus_out        <= '0;
      bus_valid      <= 1'b0;
      bus_src        <= '0;
      conflict       <= 1'b0;
      conflict_count <= '0;
      ptr            <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      conflict <= 1'b0;
      if (capture) begin
        if (win_found) begin
          bus_out   <= win_data;
          bus_src   <= win_idx;
          bus_valid <= 1'b1;
          if (MODE == ARB_RR) ptr <= next_ptr;
        end else begin
          bus_valid <= 1'b0;
          bus_src   <= '0;
          if (HOLD == 0) bus_out <= '0;
        end
        if (multi) begin
          conflict <= 1'b1;
          if (conflict_count != '1) conflict_count <= conflict_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arb_reg.sv
// Directed self-checking bench for bus_arb_reg: a fixed-priority instance
// (NSRC=24, HOLD=0) and a round-robin instance (NSRC=4, HOLD=1).
module tb_bus_arb_reg;
  import bus_pkg::*;

  localparam int W  = 32;
  localparam int NF = 24;
  localparam int NR = 4;

  logic clock = 1'b0;
  logic clear;

  logic [NF-1:0]   f_sel;
  logic [NF*W-1:0] f_data;
  logic            f_rdy;
  logic [W-1:0]    f_out;
  logic            f_valid;
  logic [4:0]      f_src;
  logic            f_conf;
  logic [15:0]     f_cnt;

  logic [NR-1:0]   r_sel;
  logic [NR*W-1:0] r_data;
  logic            r_rdy;
  logic [W-1:0]    r_out;
  logic            r_valid;
  logic [1:0]      r_src;
  logic            r_conf;
  logic [15:0]     r_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  bus_arb_reg #(.WIDTH(W), .NSRC(NF), .MODE(ARB_FIXED), .HOLD(0)) u_fix (
    .clock (clock), .clear (clear), .sel (f_sel), .data_in (f_data),
    .out_ready (f_rdy), .bus_out (f_out), .bus_valid (f_valid),
    .bus_src (f_src), .conflict (f_conf), .conflict_count (f_cnt)
  );

  bus_arb_reg #(.WIDTH(W), .NSRC(NR), .MODE(ARB_RR), .HOLD(1)) u_rr (
    .clock (clock), .clear (clear), .sel (r_sel), .data_in (r_data),
    .out_ready (r_rdy), .bus_out (r_out), .bus_valid (r_valid),
    .bus_src (r_src), .conflict (r_conf), .conflict_count (r_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_f(input string tag, input logic [31:0] out, input logic [4:0] src,
                       input logic valid, input logic conf, input logic [15:0] cnt);
    chk({tag, ".f_out"},   f_out,   out);
    chk({tag, ".f_src"},   f_src,   src);
    chk({tag, ".f_valid"}, f_valid, valid);
    chk({tag, ".f_conf"},  f_conf,  conf);
    chk({tag, ".f_cnt"},   f_cnt,   cnt);
  endtask

  task automatic chk_r(input string tag, input logic [31:0] out, input logic [1:0] src,
                       input logic valid, input logic conf);
    chk({tag, ".r_out"},   r_out,   out);
    chk({tag, ".r_src"},   r_src,   src);
    chk({tag, ".r_valid"}, r_valid, valid);
    chk({tag, ".r_conf"},  r_conf,  conf);
  endtask

  initial begin
    clear  = 1'b1;
    f_sel  = '0;
    f_rdy  = 1'b1;
    r_sel  = '0;
    r_rdy  = 1'b1;
    f_data = '0;
    r_data = '0;
    for (int i = 0; i < NF; i++) f_data[i*W +: W] = 32'h0000_0100 + i;
    for (int i = 0; i < NR; i++) r_data[i*W +: W] = 32'hC0DE_0000 + i;
    f_data[0*W +: W]  = 32'hAAAA_0000;
    f_data[1*W +: W]  = 32'h1111_1111;
    f_data[2*W +: W]  = 32'h0000_2222;
    f_data[4*W +: W]  = 32'h0000_1234;
    f_data[23*W +: W] = 32'hDEAD_0023;

    // Reset state
    step();
    chk_f("reset", 32'h0, 5'd0, 1'b0, 1'b0, 16'h0);
    chk_r("reset", 32'h0, 2'd0, 1'b0, 1'b0);
    chk("reset.r_cnt", r_cnt, 16'h0);
    clear = 1'b0;

    // Fixed priority: lowest index of two requesters, conflict flagged
    f_sel = 24'h000005;
    step();
    chk_f("fix_conf", 32'hAAAA_0000, 5'd0, 1'b1, 1'b1, 16'd1);

    // Top source index alone
    f_sel = 24'h800000;
    step();
    chk_f("fix_top", 32'hDEAD_0023, 5'd23, 1'b1, 1'b0, 16'd1);

    // Stall: word held, sel changing (including X) is ignored
    f_rdy = 1'b0;
    f_sel = 24'h000006;
    step();
    chk_f("fix_stall0", 32'hDEAD_0023, 5'd23, 1'b1, 1'b0, 16'd1);
    f_sel = 'x;
    step();
    chk_f("fix_stall1", 32'hDEAD_0023, 5'd23, 1'b1, 1'b0, 16'd1);
    f_sel = 24'h000003;
    step();
    chk_f("fix_stall2", 32'hDEAD_0023, 5'd23, 1'b1, 1'b0, 16'd1);
    f_rdy = 1'b1;
    f_sel = 24'h000006;
    step();
    chk_f("fix_resume", 32'h1111_1111, 5'd1, 1'b1, 1'b1, 16'd2);

    // Idle with HOLD=0
    f_sel = 24'h000010;
    step();
    chk_f("fix_word", 32'h0000_1234, 5'd4, 1'b1, 1'b0, 16'd2);
    f_sel = '0;
    step();
    chk_f("fix_idle", 32'h0, 5'd0, 1'b0, 1'b0, 16'd2);

    // Round robin: sel=F for 5 captures -> 0,1,2,3,0
    r_sel = 4'hF;
    step(); chk_r("rr0", 32'hC0DE_0000, 2'd0, 1'b1, 1'b1);
    step(); chk_r("rr1", 32'hC0DE_0001, 2'd1, 1'b1, 1'b1);
    step(); chk_r("rr2", 32'hC0DE_0002, 2'd2, 1'b1, 1'b1);
    step(); chk_r("rr3", 32'hC0DE_0003, 2'd3, 1'b1, 1'b1);
    step(); chk_r("rr4", 32'hC0DE_0000, 2'd0, 1'b1, 1'b1);
    chk("rr4.r_cnt", r_cnt, 16'd5);

    // RR stall: pointer frozen at 1
    r_rdy = 1'b0;
    r_sel = 4'h1; step(); chk_r("rr_stall0", 32'hC0DE_0000, 2'd0, 1'b1, 1'b0);
    r_sel = 4'h8; step(); chk_r("rr_stall1", 32'hC0DE_0000, 2'd0, 1'b1, 1'b0);
    r_sel = 'x;   step(); chk_r("rr_stall2", 32'hC0DE_0000, 2'd0, 1'b1, 1'b0);
    r_rdy = 1'b1;
    r_sel = 4'hF; step(); chk_r("rr_resume", 32'hC0DE_0001, 2'd1, 1'b1, 1'b1);
    chk("rr_resume.r_cnt", r_cnt, 16'd6);

    // Sole requester below the pointer (ptr=2), then wrap search (ptr=2 -> 0)
    r_sel = 4'h2; step(); chk_r("rr_sole", 32'hC0DE_0001, 2'd1, 1'b1, 1'b0);
    r_sel = 4'h1; step(); chk_r("rr_wrap", 32'hC0DE_0000, 2'd0, 1'b1, 1'b0);
    // ptr=1: bits 0,3 -> 3; then ptr wraps to 0 -> 0
    r_sel = 4'h9; step(); chk_r("rr_9a", 32'hC0DE_0003, 2'd3, 1'b1, 1'b1);
    step();               chk_r("rr_9b", 32'hC0DE_0000, 2'd0, 1'b1, 1'b1);

    // Idle with HOLD=1 (ptr=1 -> grant 2 -> ptr=3)
    r_data[2*W +: W] = 32'h0000_1234;
    r_sel = 4'h4; step(); chk_r("rr_word", 32'h0000_1234, 2'd2, 1'b1, 1'b0);
    r_sel = 4'h0; step(); chk_r("rr_idle0", 32'h0000_1234, 2'd0, 1'b0, 1'b0);
    step();               chk_r("rr_idle1", 32'h0000_1234, 2'd0, 1'b0, 1'b0);
    r_sel = 4'hF; step(); chk_r("rr_after_idle", 32'hC0DE_0003, 2'd3, 1'b1, 1'b1);
    r_sel = 4'h2; step(); chk_r("rr_ptr2", 32'hC0DE_0001, 2'd1, 1'b1, 1'b0);
    r_sel = 4'h0;

    // Saturation: clear then 65537 conflict captures on the fixed instance
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_f("sat_clr", 32'h0, 5'd0, 1'b0, 1'b0, 16'h0);
    f_sel = 24'h000003;
    repeat (65534) @(posedge clock);
    #1;
    chk("sat_fffe", f_cnt, 16'hFFFE);
    step();
    chk("sat_ffff", f_cnt, 16'hFFFF);
    step();
    step();
    chk_f("sat_hold", 32'hAAAA_0000, 5'd0, 1'b1, 1'b1, 16'hFFFF);

    // Asynchronous clear between edges while bus_valid=1
    r_sel = 4'h2;
    step();
    chk("pre_clr.r_valid", r_valid, 1'b1);
    #2 clear = 1'b1;
    #1;
    chk_f("async_clr", 32'h0, 5'd0, 1'b0, 1'b0, 16'h0);
    chk_r("async_clr", 32'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    clear = 1'b0;

    // First capture after release behaves as from power-up (RR ptr back to 0)
    f_sel = 24'h000005;
    r_sel = 4'hF;
    step();
    chk_f("post_clr", 32'hAAAA_0000, 5'd0, 1'b1, 1'b1, 16'd1);
    chk_r("post_clr", 32'hC0DE_0000, 2'd0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
